// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: display reads own the RAM in active video; host writes drain from a one-entry buffer in blanking.
// Optional VGA_FB_SCALE2_EN: 320x240 fetch with pixel/line doubling; output pipeline latency is 1 cycle.
module vga_fb_arbiter #(
  parameter int H_ACT = 640,
  parameter int V_ACT = 480,
  parameter int AW    = 19,
  parameter int DW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic          videoon,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_data,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid,
  output logic          hsync,
  output logic          vsync,
  output logic          host_pending
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } hold_state_e;

  hold_state_e   state_q, state_d;
  logic [AW-1:0] hold_addr_q, hold_addr_d;
  logic [DW-1:0] hold_data_q, hold_data_d;
  logic [AW-1:0] line_base_q, line_base_d;
  logic          pix_valid_q, hsync_q, vsync_q;

  logic [AW-1:0] fetch_off;
  logic [AW-1:0] line_step;
  logic          line_end;
  logic          frame_blank;

`ifdef VGA_FB_SCALE2_EN
  // Each stored line is shown twice, so the base only moves after odd lines.
  assign fetch_off = AW'(x >> 1);
  assign line_step = AW'(H_ACT / 2);
  assign line_end  = videoon && (x == 10'(H_ACT - 1)) && y[0];
`else
  assign fetch_off = AW'(x);
  assign line_step = AW'(H_ACT);
  assign line_end  = videoon && (x == 10'(H_ACT - 1));
`endif

  assign frame_blank = (y >= 10'(V_ACT));

  always_comb begin
    line_base_d = line_base_q;
    if (frame_blank) begin
      line_base_d = '0;
    end else if (line_end) begin
      line_base_d = line_base_q + line_step;
    end
  end

  // Holding register: a retiring entry blocks acceptance for that cycle.
  always_comb begin
    state_d     = state_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    host_ready  = 1'b0;
    case (state_q)
      S_EMPTY: begin
        host_ready = !reset;
        if (host_valid && !reset) begin
          hold_addr_d = host_addr;
          hold_data_d = host_data;
          state_d     = S_FULL;
        end
      end
      S_FULL: begin
        if (!videoon) begin
          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = line_base_q + fetch_off;
    mem_wdata = hold_data_q;
    if (reset) begin
      mem_en = 1'b0;
    end else if (videoon) begin
      mem_en = 1'b1;
    end else if (state_q == S_FULL) begin
      mem_en   = 1'b1;
      mem_we   = 1'b1;
      mem_addr = hold_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      line_base_q <= '0;
      pix_valid_q <= 1'b0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      line_base_q <= line_base_d;
      pix_valid_q <= videoon;
      hsync_q     <= hsync_in;
      vsync_q     <= vsync_in;
    end
  end

  always_ff @(posedge clk) begin
    hold_addr_q <= hold_addr_d;
    hold_data_q <= hold_data_d;
  end

  assign pix_valid    = pix_valid_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign pix_data     = pix_valid_q ? mem_rdata : '0;
  assign host_pending = (state_q == S_FULL);

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: stimulus pushes expected reads, writes and pixels; a negedge monitor pops and compares.
module tb_vga_fb_arbiter;
  localparam int AW = 19;
  localparam int DW = 12;

  logic          clk;
  logic          reset;
  logic [9:0]    x, y;
  logic          videoon, hsync_in, vsync_in;
  logic          host_valid, host_ready;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_data;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [DW-1:0] pix_data;
  logic          pix_valid, hsync, vsync, host_pending;

  vga_fb_arbiter #(.H_ACT(640), .V_ACT(480), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .videoon(videoon),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .host_valid(host_valid), .host_ready(host_ready),
    .host_addr(host_addr), .host_data(host_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pix_data(pix_data), .pix_valid(pix_valid),
    .hsync(hsync), .vsync(vsync), .host_pending(host_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_rd = 0, n_wr = 0, n_acc = 0, n_pushed = 0;
  logic [AW-1:0] last_rd = '0;

  int                 rd_q[$];
  logic [DW-1:0]      pix_q[$];
  logic [AW+DW-1:0]   wr_q[$];

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic int exp_addr(input int xx, input int yy);
`ifdef VGA_FB_SCALE2_EN
    return (yy / 2) * 320 + xx / 2;
`else
    return yy * 640 + xx;
`endif
  endfunction

  function automatic logic [DW-1:0] pat(input int a);
    return 12'(a) ^ 12'h5A5;
  endfunction

  // Pixels the RAM is known to hold at the time the bench reads them.
  function automatic logic [DW-1:0] exp_pix(input int a);
    if (a == exp_addr(5, 2)) return 12'hABC;
    if (a == 100) return 12'h0F0;
    return pat(a);
  endfunction

  // Single-port synchronous RAM model; unwritten words hold a fixed pattern.
  logic [DW-1:0] ram [int];
  initial ram[exp_addr(5, 2)] = 12'hABC;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[int'(mem_addr)] = mem_wdata;
      else mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : pat(int'(mem_addr));
    end
  end

  // Monitor
  logic prv_rst = 1'b1, prv_von = 1'b0, prv_hs = 1'b1, prv_vs = 1'b1, prv_acc = 1'b0;
  always @(negedge clk) begin
    logic acc;
    logic exp_pv, exp_hs, exp_vs;
    logic [AW+DW-1:0] w;
    int a;
    logic [DW-1:0] p;
    exp_pv = prv_rst ? 1'b0 : prv_von;
    exp_hs = prv_rst ? 1'b1 : prv_hs;
    exp_vs = prv_rst ? 1'b1 : prv_vs;
    chk(pix_valid == exp_pv, "pix_valid_dly", 32'(pix_valid), 32'(exp_pv));
    chk(hsync == exp_hs, "hsync_dly", 32'(hsync), 32'(exp_hs));
    chk(vsync == exp_vs, "vsync_dly", 32'(vsync), 32'(exp_vs));
    if (pix_valid) begin
      if (pix_q.size() == 0) chk(1'b0, "pix_unexpected", 32'(pix_data), 0);
      else begin
        p = pix_q.pop_front();
        chk(pix_data == p, "pix_data", 32'(pix_data), 32'(p));
      end
    end else begin
      chk(pix_data == '0, "pix_blank_zero", 32'(pix_data), 0);
    end
    if (reset) begin
      chk(mem_en == 1'b0, "rst_mem_en", 32'(mem_en), 0);
      chk(host_ready == 1'b0, "rst_host_ready", 32'(host_ready), 0);
    end
    if (mem_en && !mem_we) begin
      n_rd++;
      last_rd = mem_addr;
      chk(videoon == 1'b1, "read_outside_active", 32'(videoon), 1);
      if (rd_q.size() == 0) chk(1'b0, "rd_unexpected", 32'(mem_addr), 0);
      else begin
        a = rd_q.pop_front();
        chk(int'(mem_addr) == a, "rd_addr", 32'(mem_addr), 32'(a));
      end
    end
    if (mem_en && mem_we) begin
      n_wr++;
      chk(videoon == 1'b0, "write_in_active", 32'(videoon), 0);
      if (wr_q.size() == 0) chk(1'b0, "wr_unexpected", 32'({mem_addr, mem_wdata}), 0);
      else begin
        w = wr_q.pop_front();
        chk({mem_addr, mem_wdata} == w, "wr_addr_data", 32'({mem_addr, mem_wdata}), 32'(w));
      end
    end
    acc = host_valid && host_ready;
    if (acc) begin
      n_acc++;
      chk(!prv_acc, "consecutive_accept", 32'(prv_acc), 0);
    end
    prv_rst = reset;
    prv_von = videoon;
    prv_hs  = hsync_in;
    prv_vs  = vsync_in;
    prv_acc = acc;
  end

  task automatic drv(input int xx, input int yy, input bit von);
    int a;
    x        = 10'(xx);
    y        = 10'(yy);
    videoon  = von;
    hsync_in = !(xx >= 656 && xx < 752);
    vsync_in = !(yy >= 490 && yy < 492);
    if (von && !reset) begin
      a = exp_addr(xx, yy);
      rd_q.push_back(a);
      pix_q.push_back(exp_pix(a));
      n_pushed++;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic bit full_line(input int yy);
    return yy inside {0, 1, 2, 4, 5, 477, 478, 479};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0, acc0;
    reset = 1'b1; host_valid = 1'b0; host_addr = '0; host_data = '0;
    x = '0; y = '0; videoon = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    drv(700, 500, 0);
    drv(700, 500, 0);
    chk(pix_valid == 1'b0, "rst_pix_valid", 32'(pix_valid), 0);
    chk(hsync == 1'b1, "rst_hsync", 32'(hsync), 1);
    chk(host_ready == 1'b0, "rst_ready", 32'(host_ready), 0);
    reset = 1'b0;
    drv(700, 500, 0);
    chk(host_ready == 1'b1, "ready_after_rst", 32'(host_ready), 1);
    chk(host_pending == 1'b0, "pending_after_rst", 32'(host_pending), 0);

    // Hold a write in active video, then reset mid-line: it must be dropped.
    host_valid = 1'b1; host_addr = 19'd7; host_data = 12'h123;
    drv(0, 0, 1);
    host_valid = 1'b0;
    chk(host_pending == 1'b1, "held_before_rst", 32'(host_pending), 1);
    for (int i = 1; i < 10; i++) drv(i, 0, 1);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) drv(10 + i, 0, 1);
    chk(pix_valid == 1'b0, "midrst_pix_valid", 32'(pix_valid), 0);
    chk(hsync == 1'b1 && vsync == 1'b1, "midrst_syncs", 32'({hsync, vsync}), 3);
    chk(host_ready == 1'b0, "midrst_ready", 32'(host_ready), 0);
    chk(host_pending == 1'b0, "midrst_pending", 32'(host_pending), 0);
    reset = 1'b0;
    drv(700, 0, 0);
    chk(host_ready == 1'b1, "ready_after_midrst", 32'(host_ready), 1);
    drv(799, 0, 0);

    // Lines 0 and 1 end at x=639, then single read at x=5, y=2.
    drv(639, 0, 1); drv(700, 0, 0); drv(799, 0, 0);
    drv(639, 1, 1); drv(700, 1, 0); drv(799, 1, 0);
    drv(5, 2, 1);

    // Host write during active video, deferred to first blank cycle.
    host_valid = 1'b1; host_addr = 19'd100; host_data = 12'h0F0;
    wr_q.push_back({19'd100, 12'h0F0});
    drv(6, 2, 1);
    host_valid = 1'b0;
    for (int i = 7; i < 16; i++) begin
      chk(host_pending == 1'b1, "pending_in_active", 32'(host_pending), 1);
      drv(i, 2, 1);
    end
    drv(640, 2, 0);
    chk(host_pending == 1'b0, "pending_after_retire", 32'(host_pending), 0);

    // Back-to-back requests through a 160-cycle blank: accept on even cycles only.
    wr0 = n_wr; acc0 = n_acc;
    host_valid = 1'b1;
    for (int i = 0; i < 160; i++) begin
      host_addr = 19'(400000 + i);
      host_data = 12'(i);
      if ((i % 2) == 0) wr_q.push_back({19'(400000 + i), 12'(i)});
      drv(640 + i, 2, 0);
    end
    host_valid = 1'b0;
    chk(n_wr - wr0 == 80, "blank_write_count", 32'(n_wr - wr0), 80);
    chk(n_acc - acc0 == 80, "blank_accept_count", 32'(n_acc - acc0), 80);

    // Vertical blank clears the base, then a compressed frame sweep.
    drv(700, 480, 0); drv(700, 490, 0); drv(700, 491, 0); drv(799, 524, 0);
    for (int yy = 0; yy < 480; yy++) begin
      if (full_line(yy)) begin
        for (int xx = 0; xx < 640; xx++) drv(xx, yy, 1);
      end else begin
        drv(639, yy, 1);
      end
      drv(700, yy, 0);
      drv(799, yy, 0);
    end
    chk(int'(last_rd) == exp_addr(639, 479), "last_read_addr", 32'(last_rd), 32'(exp_addr(639, 479)));
    drv(700, 480, 0);
    drv(0, 0, 1);
    chk(mem_addr == '0, "base_cleared_next_frame", 32'(mem_addr), 0);
    drv(700, 0, 0);
    drv(700, 0, 0);

    chk(rd_q.size() == 0, "rd_queue_drained", 32'(rd_q.size()), 0);
    chk(wr_q.size() == 0, "wr_queue_drained", 32'(wr_q.size()), 0);
    chk(pix_q.size() == 0, "pix_queue_drained", 32'(pix_q.size()), 0);
    chk(n_rd == n_pushed, "read_count", 32'(n_rd), 32'(n_pushed));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
